// File: rtl/cpu_bus_arbiter_pkg.sv
// cpu_bus_arbiter_pkg
// Shared types and constants for the CPU/DMA bus arbiter.
//   arb_state_t : arbiter FSM state codes (idle, busy, release)
//   GRANT_*     : encoding of the single registered grant bit
//   WAIT_W      : width of the BUSY wait counter
//   pick_grant  : round-robin master selection
package cpu_bus_arbiter_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE    = 2'b00,
        ARB_BUSY    = 2'b01,
        ARB_RELEASE = 2'b10
    } arb_state_t;

    localparam logic GRANT_CPU = 1'b0;
    localparam logic GRANT_DMA = 1'b1;
    localparam int   WAIT_W    = 8;

    // A tie goes to whichever master was not served last; otherwise the
    // single requester wins.
    function automatic logic pick_grant(input logic cpu_req,
                                        input logic dma_req,
                                        input logic last_grant);
        logic sel;
        if (cpu_req && dma_req) begin
            sel = ~last_grant;
        end else if (dma_req) begin
            sel = GRANT_DMA;
        end else begin
            sel = GRANT_CPU;
        end
        return sel;
    endfunction

endpackage

// File: rtl/cpu_bus_arbiter_wait_timer.sv
// arb_wait_timer
// Counts BUSY cycles spent waiting for the memory acknowledge.
//   clk, reset : clock, asynchronous active-low reset
//   clear      : zero the counter (asserted on entry to BUSY)
//   enable     : advance the counter (a BUSY cycle without mem_ack)
//   expired    : the count reaches TIMEOUT at the next advance
module arb_wait_timer
    import cpu_bus_arbiter_pkg::*;
#(
    parameter int TIMEOUT = 15
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    logic [WAIT_W-1:0] count_r;

    // Wait counter: cleared on BUSY entry, stepped on every un-acked cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_r <= 8'd0;
        end else if (clear) begin
            count_r <= 8'd0;
        end else if (enable) begin
            count_r <= count_r + 8'd1;
        end else begin
            count_r <= count_r;
        end
    end

    // Flag the cycle whose increment would make the count equal TIMEOUT, so
    // the arbiter can give up on that same cycle (TIMEOUT BUSY cycles total).
    assign expired = (count_r == WAIT_W'(TIMEOUT - 1));

endmodule

// File: rtl/cpu_bus_arbiter.sv
// cpu_bus_arbiter
// Two-master (CPU, DMA) arbiter for one shared memory bus with round-robin
// tie break and an acknowledge timeout.
//   clk, reset                 : clock, asynchronous active-low reset
//   cpu_req/we/addr/wdata      : CPU request, held until cpu_ready
//   cpu_rdata/ready/err        : CPU read data, completion pulse, timeout flag
//   dma_*                      : same set for the DMA/loader master
//   mem_en/we/addr/wdata       : shared bus, driven from latched request
//   mem_rdata, mem_ack         : memory read data and completion
module cpu_bus_arbiter
    import cpu_bus_arbiter_pkg::*;
#(
    parameter int ADDR_W  = 16,
    parameter int DATA_W  = 16,
    parameter int TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_ready,
    output logic              cpu_err,
    input  logic              dma_req,
    input  logic              dma_we,
    input  logic [ADDR_W-1:0] dma_addr,
    input  logic [DATA_W-1:0] dma_wdata,
    output logic [DATA_W-1:0] dma_rdata,
    output logic              dma_ready,
    output logic              dma_err,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack
);

    arb_state_t        state_r, state_next_s;
    logic              grant_r;
    logic              start_s, sel_dma_s, done_ack_s, done_timeout_s;
    logic              timer_clear_s, timer_en_s, expired_s;
    logic              mem_en_r, mem_we_r;
    logic [ADDR_W-1:0] mem_addr_r;
    logic [DATA_W-1:0] mem_wdata_r;
    logic [DATA_W-1:0] cpu_rdata_r, dma_rdata_r;
    logic              cpu_ready_r, cpu_err_r, dma_ready_r, dma_err_r;

    arb_wait_timer #(.TIMEOUT(TIMEOUT)) u_wait_timer (
        .clk     (clk),
        .reset   (reset),
        .clear   (timer_clear_s),
        .enable  (timer_en_s),
        .expired (expired_s)
    );

    // FSM state register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= ARB_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state and per-cycle control decode.
    always_comb begin
        state_next_s   = state_r;
        start_s        = 1'b0;
        sel_dma_s      = grant_r;
        done_ack_s     = 1'b0;
        done_timeout_s = 1'b0;
        timer_clear_s  = 1'b0;
        timer_en_s     = 1'b0;
        case (state_r)
            ARB_IDLE: begin
                if (cpu_req || dma_req) begin
                    start_s       = 1'b1;
                    sel_dma_s     = pick_grant(cpu_req, dma_req, grant_r);
                    timer_clear_s = 1'b1;
                    state_next_s  = ARB_BUSY;
                end else begin
                    state_next_s  = ARB_IDLE;
                end
            end
            ARB_BUSY: begin
                // An ack on the expiry cycle still counts as a good transfer.
                if (mem_ack) begin
                    done_ack_s     = 1'b1;
                    state_next_s   = ARB_RELEASE;
                end else if (expired_s) begin
                    done_timeout_s = 1'b1;
                    timer_en_s     = 1'b1;
                    state_next_s   = ARB_RELEASE;
                end else begin
                    timer_en_s     = 1'b1;
                    state_next_s   = ARB_BUSY;
                end
            end
            ARB_RELEASE: begin
                state_next_s = ARB_IDLE;
            end
            default: begin
                state_next_s = ARB_IDLE;
            end
        endcase
    end

    // Grant, latched bus request and per-master response registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            grant_r     <= GRANT_DMA;
            mem_en_r    <= 1'b0;
            mem_we_r    <= 1'b0;
            mem_addr_r  <= {ADDR_W{1'b0}};
            mem_wdata_r <= {DATA_W{1'b0}};
            cpu_rdata_r <= {DATA_W{1'b0}};
            dma_rdata_r <= {DATA_W{1'b0}};
            cpu_ready_r <= 1'b0;
            cpu_err_r   <= 1'b0;
            dma_ready_r <= 1'b0;
            dma_err_r   <= 1'b0;
        end else begin
            // ready/err are single-cycle pulses.
            cpu_ready_r <= 1'b0;
            cpu_err_r   <= 1'b0;
            dma_ready_r <= 1'b0;
            dma_err_r   <= 1'b0;
            if (start_s) begin
                grant_r     <= sel_dma_s;
                mem_en_r    <= 1'b1;
                mem_we_r    <= sel_dma_s ? dma_we    : cpu_we;
                mem_addr_r  <= sel_dma_s ? dma_addr  : cpu_addr;
                mem_wdata_r <= sel_dma_s ? dma_wdata : cpu_wdata;
            end else if (done_ack_s) begin
                mem_en_r <= 1'b0;
                if (grant_r == GRANT_DMA) begin
                    dma_ready_r <= 1'b1;
                    if (!mem_we_r) begin
                        dma_rdata_r <= mem_rdata;
                    end
                end else begin
                    cpu_ready_r <= 1'b1;
                    if (!mem_we_r) begin
                        cpu_rdata_r <= mem_rdata;
                    end
                end
            end else if (done_timeout_s) begin
                mem_en_r <= 1'b0;
                if (grant_r == GRANT_DMA) begin
                    dma_ready_r <= 1'b1;
                    dma_err_r   <= 1'b1;
                    dma_rdata_r <= {DATA_W{1'b1}};
                end else begin
                    cpu_ready_r <= 1'b1;
                    cpu_err_r   <= 1'b1;
                    cpu_rdata_r <= {DATA_W{1'b1}};
                end
            end
        end
    end

    assign mem_en    = mem_en_r;
    assign mem_we    = mem_we_r;
    assign mem_addr  = mem_addr_r;
    assign mem_wdata = mem_wdata_r;
    assign cpu_rdata = cpu_rdata_r;
    assign cpu_ready = cpu_ready_r;
    assign cpu_err   = cpu_err_r;
    assign dma_rdata = dma_rdata_r;
    assign dma_ready = dma_ready_r;
    assign dma_err   = dma_err_r;

endmodule

// File: tb/tb_cpu_bus_arbiter.sv
// tb_cpu_bus_arbiter
// Directed self-checking bench for cpu_bus_arbiter (default parameters).
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_cpu_bus_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        cpu_req, cpu_we, dma_req, dma_we, mem_ack;
    logic [15:0] cpu_addr, cpu_wdata, dma_addr, dma_wdata, mem_rdata;
    logic [15:0] cpu_rdata, dma_rdata, mem_addr, mem_wdata;
    logic        cpu_ready, cpu_err, dma_ready, dma_err, mem_en, mem_we;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    cpu_bus_arbiter dut (
        .clk       (clk),
        .reset     (reset),
        .cpu_req   (cpu_req),
        .cpu_we    (cpu_we),
        .cpu_addr  (cpu_addr),
        .cpu_wdata (cpu_wdata),
        .cpu_rdata (cpu_rdata),
        .cpu_ready (cpu_ready),
        .cpu_err   (cpu_err),
        .dma_req   (dma_req),
        .dma_we    (dma_we),
        .dma_addr  (dma_addr),
        .dma_wdata (dma_wdata),
        .dma_rdata (dma_rdata),
        .dma_ready (dma_ready),
        .dma_err   (dma_err),
        .mem_en    (mem_en),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ack   (mem_ack)
    );

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic test_reset();
        step(2);
        checks++; if (mem_en !== 1'b0) begin errors++; $display("FAIL reset_mem_en: got %b want 0", mem_en); end
        checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL reset_mem_we: got %b want 0", mem_we); end
        checks++; if (mem_addr !== 16'h0000) begin errors++; $display("FAIL reset_mem_addr: got %h want 0000", mem_addr); end
        checks++; if (mem_wdata !== 16'h0000) begin errors++; $display("FAIL reset_mem_wdata: got %h want 0000", mem_wdata); end
        checks++; if ({cpu_ready, cpu_err, dma_ready, dma_err} !== 4'b0000) begin errors++; $display("FAIL reset_flags: got %b want 0000", {cpu_ready, cpu_err, dma_ready, dma_err}); end
        checks++; if (cpu_rdata !== 16'h0000) begin errors++; $display("FAIL reset_cpu_rdata: got %h want 0000", cpu_rdata); end
        checks++; if (dma_rdata !== 16'h0000) begin errors++; $display("FAIL reset_dma_rdata: got %h want 0000", dma_rdata); end
        reset = 1'b1;
        step(1);
    endtask

    task automatic test_cpu_read();
        // Stray ack while idle must do nothing.
        mem_ack = 1'b1;
        step(1);
        mem_ack = 1'b0;
        checks++; if ({mem_en, cpu_ready, dma_ready} !== 3'b000) begin errors++; $display("FAIL idle_ack_ignored: got %b want 000", {mem_en, cpu_ready, dma_ready}); end
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0010;
        step(1);
        checks++; if ({mem_en, mem_we} !== 2'b10) begin errors++; $display("FAIL read_latency_en_we: got %b want 10", {mem_en, mem_we}); end
        checks++; if (mem_addr !== 16'h0010) begin errors++; $display("FAIL read_addr: got %h want 0010", mem_addr); end
        cpu_req = 1'b0;  // dropping req while granted must not abort
        step(1);
        checks++; if ({mem_en, cpu_ready} !== 2'b10) begin errors++; $display("FAIL read_no_abort: got %b want 10", {mem_en, cpu_ready}); end
        step(2);
        mem_ack = 1'b1; mem_rdata = 16'hBEEF;
        step(1);
        mem_ack = 1'b0; mem_rdata = 16'h0000;
        checks++; if (cpu_ready !== 1'b1) begin errors++; $display("FAIL read_ready: got %b want 1", cpu_ready); end
        checks++; if (cpu_rdata !== 16'hBEEF) begin errors++; $display("FAIL read_rdata: got %h want beef", cpu_rdata); end
        checks++; if ({cpu_err, dma_ready, dma_err, mem_en} !== 4'b0000) begin errors++; $display("FAIL read_other_flags: got %b want 0000", {cpu_err, dma_ready, dma_err, mem_en}); end
        step(1);
        checks++; if (cpu_ready !== 1'b0) begin errors++; $display("FAIL read_ready_one_cycle: got %b want 0", cpu_ready); end
        checks++; if (cpu_rdata !== 16'hBEEF) begin errors++; $display("FAIL read_rdata_hold: got %h want beef", cpu_rdata); end
        step(1);
        checks++; if (mem_en !== 1'b0) begin errors++; $display("FAIL idle_no_req: got %b want 0", mem_en); end
    endtask

    task automatic test_cpu_write();
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 16'h0044; cpu_wdata = 16'hA5A5;
        step(1);
        checks++; if ({mem_en, mem_we} !== 2'b11) begin errors++; $display("FAIL write_en_we: got %b want 11", {mem_en, mem_we}); end
        checks++; if (mem_wdata !== 16'hA5A5) begin errors++; $display("FAIL write_wdata: got %h want a5a5", mem_wdata); end
        mem_ack = 1'b1; mem_rdata = 16'h1111;
        step(1);
        mem_ack = 1'b0; cpu_req = 1'b0; cpu_we = 1'b0;
        checks++; if ({cpu_ready, cpu_err} !== 2'b10) begin errors++; $display("FAIL write_ready: got %b want 10", {cpu_ready, cpu_err}); end
        checks++; if (cpu_rdata !== 16'hBEEF) begin errors++; $display("FAIL write_keeps_rdata: got %h want beef", cpu_rdata); end
        step(1);
    endtask

    task automatic test_dma_timeout();
        dma_req = 1'b1; dma_we = 1'b1; dma_addr = 16'h0200; dma_wdata = 16'h1234;
        step(1);
        dma_addr = 16'h0F0F; dma_wdata = 16'h0000;  // live inputs must not reach the bus
        for (int i = 1; i <= 15; i++) begin
            checks++; if ({mem_en, mem_we} !== 2'b11) begin errors++; $display("FAIL timeout_busy_en_we cycle %0d: got %b want 11", i, {mem_en, mem_we}); end
            checks++; if ({mem_addr, mem_wdata} !== {16'h0200, 16'h1234}) begin errors++; $display("FAIL timeout_latched cycle %0d: got %h want 02001234", i, {mem_addr, mem_wdata}); end
            checks++; if ({dma_ready, cpu_ready} !== 2'b00) begin errors++; $display("FAIL timeout_early_ready cycle %0d: got %b want 00", i, {dma_ready, cpu_ready}); end
            step(1);
        end
        checks++; if ({dma_ready, dma_err} !== 2'b11) begin errors++; $display("FAIL timeout_ready_err: got %b want 11", {dma_ready, dma_err}); end
        checks++; if (dma_rdata !== 16'hFFFF) begin errors++; $display("FAIL timeout_rdata: got %h want ffff", dma_rdata); end
        checks++; if ({cpu_ready, cpu_err, mem_en} !== 3'b000) begin errors++; $display("FAIL timeout_others: got %b want 000", {cpu_ready, cpu_err, mem_en}); end
        dma_req = 1'b0; dma_we = 1'b0;
        step(1);
        checks++; if ({dma_ready, dma_err} !== 2'b00) begin errors++; $display("FAIL timeout_pulse_one_cycle: got %b want 00", {dma_ready, dma_err}); end
    endtask

    task automatic test_ack_at_timeout();
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0030;
        step(1);
        cpu_addr = 16'hFFFF;  // latched address must hold
        step(14);
        checks++; if ({mem_en, cpu_ready} !== 2'b10) begin errors++; $display("FAIL edge_cycle15_busy: got %b want 10", {mem_en, cpu_ready}); end
        checks++; if (mem_addr !== 16'h0030) begin errors++; $display("FAIL edge_addr_hold: got %h want 0030", mem_addr); end
        mem_ack = 1'b1; mem_rdata = 16'h5A5A;
        step(1);
        mem_ack = 1'b0; cpu_req = 1'b0;
        checks++; if ({cpu_ready, cpu_err} !== 2'b10) begin errors++; $display("FAIL edge_ack_wins: got %b want 10", {cpu_ready, cpu_err}); end
        checks++; if (cpu_rdata !== 16'h5A5A) begin errors++; $display("FAIL edge_rdata: got %h want 5a5a", cpu_rdata); end
        step(1);
    endtask

    task automatic test_round_robin();
        logic        exp_dma;
        logic [15:0] exp_addr;
        reset = 1'b0;
        cpu_req = 1'b1; dma_req = 1'b1; cpu_we = 1'b0; dma_we = 1'b0;
        cpu_addr = 16'h1000; dma_addr = 16'h2000;
        step(1);
        reset = 1'b1;
        for (int i = 0; i < 6; i++) begin
            exp_dma  = i[0];
            exp_addr = exp_dma ? 16'h2000 : 16'h1000;
            step(1);
            checks++; if (mem_addr !== exp_addr) begin errors++; $display("FAIL rr_grant %0d: got %h want %h", i, mem_addr, exp_addr); end
            mem_ack = 1'b1; mem_rdata = 16'h0100 + 16'(i);
            step(1);
            mem_ack = 1'b0;
            checks++; if ({cpu_ready, dma_ready} !== {~exp_dma, exp_dma}) begin errors++; $display("FAIL rr_ready %0d: got %b want %b", i, {cpu_ready, dma_ready}, {~exp_dma, exp_dma}); end
            step(1);
        end
        cpu_req = 1'b0; dma_req = 1'b0;
        step(1);
    endtask

    task automatic test_reset_mid_busy();
        cpu_req = 1'b1; cpu_addr = 16'h0123;
        step(2);
        #2 reset = 1'b0;
        #1;
        checks++; if (mem_en !== 1'b0) begin errors++; $display("FAIL async_reset_mem_en: got %b want 0", mem_en); end
        dma_req = 1'b1;
        step(1);
        checks++; if ({cpu_ready, dma_ready, mem_en} !== 3'b000) begin errors++; $display("FAIL reset_no_ready: got %b want 000", {cpu_ready, dma_ready, mem_en}); end
        reset = 1'b1;
        step(1);
        checks++; if ({mem_en, mem_addr} !== {1'b1, 16'h0123}) begin errors++; $display("FAIL reset_tie_cpu: got %h want 10123", {mem_en, mem_addr}); end
        mem_ack = 1'b1;
        step(1);
        mem_ack = 1'b0; cpu_req = 1'b0; dma_req = 1'b0;
        checks++; if ({cpu_ready, dma_ready} !== 2'b10) begin errors++; $display("FAIL reset_after_ready: got %b want 10", {cpu_ready, dma_ready}); end
        step(2);
    endtask

    initial begin
        reset = 1'b0;
        cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = 16'h0000; cpu_wdata = 16'h0000;
        dma_req = 1'b0; dma_we = 1'b0; dma_addr = 16'h0000; dma_wdata = 16'h0000;
        mem_ack = 1'b0; mem_rdata = 16'h0000;
        test_reset();
        test_cpu_read();
        test_cpu_write();
        test_dma_timeout();
        test_ack_at_timeout();
        test_round_robin();
        test_reset_mid_busy();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/cpu_bus_arbiter.md
CPU_BUS_ARBITER -- requirements
Module: cpu_bus_arbiter

Interface
REQ-001 Parameter ADDR_W, default 16, address width of all ports.
REQ-002 Parameter DATA_W, default 16, data width of all ports.
REQ-003 Parameter TIMEOUT, default 15, max BUSY cycles waiting for mem_ack; legal range 1..255.
REQ-004 clk  in  1  single clock; all state updates on rising edge.
REQ-005 reset  in  1  asynchronous, active-low reset.
REQ-006 cpu_req, cpu_we  in  1 each  CPU master request and write-enable; held stable until cpu_ready.
REQ-007 cpu_addr  in  ADDR_W; cpu_wdata  in  DATA_W  CPU transfer address and write data.
REQ-008 cpu_rdata  out  DATA_W; cpu_ready  out  1; cpu_err  out  1  CPU read data, completion pulse, timeout flag.
REQ-009 dma_req, dma_we, dma_addr, dma_wdata, dma_rdata, dma_ready, dma_err: as REQ-006..008, for the DMA/loader master.
REQ-010 mem_en  out  1; mem_we  out  1; mem_addr  out  ADDR_W; mem_wdata  out  DATA_W  shared external bus.
REQ-011 mem_rdata  in  DATA_W; mem_ack  in  1  memory read data and completion.

Function
REQ-012 FSM states SHALL be ARB_IDLE, ARB_BUSY, ARB_RELEASE.
REQ-013 ARB_IDLE, no request: remain; mem_en=0.
REQ-014 ARB_IDLE, exactly one request: grant that master, latch its we/addr/wdata, go to ARB_BUSY next cycle.
REQ-015 ARB_IDLE, both requests same cycle: grant the master not granted last (round-robin); after reset the CPU wins first tie.
REQ-016 ARB_BUSY: mem_en=1; mem_we/mem_addr/mem_wdata driven from latched values, not live master inputs.
REQ-017 ARB_BUSY, mem_ack=1: latch mem_rdata into granted master's rdata (reads only; writes leave rdata unchanged), pulse its ready for exactly one cycle on the next cycle, err=0, go to ARB_RELEASE.
REQ-018 ARB_BUSY: an 8-bit wait counter SHALL clear on entry and increment each cycle without mem_ack.
REQ-019 Counter reaching TIMEOUT without mem_ack: pulse granted ready and err for one cycle, rdata = all ones, go to ARB_RELEASE.
REQ-020 mem_ack on the same cycle the counter reaches TIMEOUT: ack wins, err=0.
REQ-021 ARB_RELEASE: mem_en=0, one cycle only, then ARB_IDLE; gives the finished master time to drop req.
REQ-022 Non-granted master's ready/err SHALL stay 0; its request waits, never dropped.
REQ-023 Latency: req high in ARB_IDLE at cycle 0 -> mem_en at cycle 1; mem_ack at cycle k -> ready at cycle k+1.
REQ-024 mem_ack outside ARB_BUSY SHALL be ignored.
REQ-025 Req deasserted by a master while granted SHALL NOT abort the transfer.

Reset
REQ-026 reset low SHALL immediately force ARB_IDLE, mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0, all ready/err=0, all rdata=0, counter=0, last-grant=DMA (so CPU wins first tie).
REQ-027 Reset asserted during ARB_BUSY SHALL abandon the transfer with no ready pulse; the first grant after release follows REQ-014/015.

Structure
REQ-028 State codes `arb_idle, `arb_busy, `arb_release SHALL be defined in the shared type.v alongside the CPU state codes.
REQ-029 Wait counter SHALL be a sub-module arb_wait_timer (clear, enable, expired output).
REQ-030 Master select SHALL be one registered grant bit; no combinational path from mem_ack to mem_en.

Verification
REQ-031 CPU read addr 0x0010, mem_ack after 3 BUSY cycles with mem_rdata 0xBEEF -> cpu_rdata=0xBEEF, cpu_ready one cycle, cpu_err=0, dma_ready=0.
REQ-032 cpu_req and dma_req both high from reset, 3 back-to-back transfers each -> grant order CPU, DMA, CPU, DMA, CPU, DMA.
REQ-033 DMA write addr 0x0200 data 0x1234, mem_ack never -> mem_we=1 for 15 cycles, then dma_ready=1, dma_err=1, dma_rdata=0xFFFF.
REQ-034 mem_ack on 15th BUSY cycle -> normal completion, err=0.
REQ-035 reset pulsed low mid ARB_BUSY -> mem_en=0 asynchronously, no ready pulse; next tie grants CPU.
REQ-036 cpu_addr changed during BUSY -> mem_addr holds latched value throughout.
